// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, in-order fetch to imem, registered instr FIFO.
// Ports: imem_req_* (fetch), imem_rsp_* (return), redirect_*, id_* (to decode).
module instruction_fetch_unit #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_WIDTH-1:0] id_instruction,
  output logic [PC_WIDTH-1:0]    id_pc,
  output logic                   id_is_fp
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    r_rsp_pc;
  logic [CNT_W-1:0]       r_out;
  logic [CNT_W-1:0]       r_drop;
  logic [CNT_W-1:0]       r_count;
  logic [PTR_W-1:0]       r_rd;
  logic [PTR_W-1:0]       r_wr;
  logic [INSTR_WIDTH-1:0] r_data [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    r_tag  [FIFO_DEPTH];

  logic                   w_credit;
  logic                   w_acc;
  logic                   w_rsp;
  logic                   w_keep;
  logic                   w_drop;
  logic                   w_pop;
  logic [PC_WIDTH-1:0]    w_redir_pc;
  logic [CNT_W-1:0]       w_drop_nxt;
  logic [INSTR_WIDTH-1:0] w_head_ins;
  logic [PC_WIDTH-1:0]    w_head_pc;
  logic [6:0]             w_op;

  // buffered + outstanding may never exceed the buffer size
  assign w_credit = ({1'b0, r_count} + {1'b0, r_out}) < DEPTH_C;

  // gated by rst_n so no request is shown while held in reset
  assign imem_req_valid = rst_n & ~redirect_valid & w_credit;
  assign imem_req_addr  = r_pc;

  assign w_acc  = imem_req_valid & imem_req_ready;
  // a response with nothing outstanding is a protocol error: ignored
  assign w_rsp  = imem_rsp_valid & (r_out != '0);
  assign w_keep = w_rsp & ~redirect_valid & (r_state == S_RUN);
  assign w_drop = w_rsp & ~redirect_valid & (r_state == S_FLUSH);
  assign w_pop  = id_valid & id_ready;

  assign w_redir_pc = redirect_pc & ~PC_WIDTH'(3);
  assign w_drop_nxt = r_out - CNT_W'(w_rsp);

  assign w_head_ins = r_data[r_rd];
  assign w_head_pc  = r_tag[r_rd];
  assign w_op       = w_head_ins[6:0];

  assign id_valid       = (r_count != '0);
  assign id_instruction = id_valid ? w_head_ins : '0;
  assign id_pc          = id_valid ? w_head_pc : '0;

  always_comb begin
    id_is_fp = 1'b0;
    if (id_valid) begin
      id_is_fp = w_op inside {
        7'b1010011, 7'b0000111, 7'b0100111,
        7'b1000011, 7'b1000111, 7'b1001011,
        7'b1001111
      };
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
    end else begin
      r_out <= r_out + CNT_W'(w_acc) - CNT_W'(w_rsp);
      if (redirect_valid) begin
        // every in-flight request is now stale
        r_pc     <= w_redir_pc;
        r_rsp_pc <= w_redir_pc;
        r_drop   <= w_drop_nxt;
        r_state  <= (w_drop_nxt != '0) ? S_FLUSH : S_RUN;
      end else begin
        if (w_acc)
          r_pc <= r_pc + PC_WIDTH'(4);
        if (w_keep)
          r_rsp_pc <= r_rsp_pc + PC_WIDTH'(4);
        if (w_drop) begin
          r_drop <= r_drop - CNT_W'(1);
          if (r_drop == CNT_W'(1))
            r_state <= S_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_keep)
        r_wr <= r_wr + PTR_W'(1);
      if (w_pop)
        r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_keep) - CNT_W'(w_pop);
    end
  end

  // payload storage needs no reset: reads are gated by id_valid
  always_ff @(posedge clk) begin
    if (w_keep) begin
      r_data[r_wr] <= imem_rsp_data;
      r_tag[r_wr]  <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: random imem model + queue scoreboard.
// Directed scenarios then a long randomized run.
module tb_instruction_fetch_unit;

  localparam int          D   = 4;
  localparam logic [63:0] RPC = 64'h0;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [63:0] id_pc;
  logic        id_is_fp;

  instruction_fetch_unit #(
    .PC_WIDTH(64), .INSTR_WIDTH(32),
    .FIFO_DEPTH(D), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instruction(id_instruction),
    .id_pc(id_pc),
    .id_is_fp(id_is_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          due;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  req_t mq[$];
  ent_t eq[$];
  logic [63:0] mpc;
  int stale_n;
  int cyc = 0;
  int last_due = 0;
  int lat_min = 1;
  int lat_max = 1;
  int data_mode = 0;
  bit spurious = 0;
  int checks = 0;
  int errors = 0;

  bit          o_acc, o_rsp, o_idv, o_rv, o_fp;
  logic [63:0] o_pc, o_addr;
  logic [31:0] o_ins;

  logic [6:0] ops [13] = '{
    7'h53, 7'h07, 7'h27, 7'h43, 7'h47, 7'h4b, 7'h4f,
    7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f
  };

  function automatic logic fp_of(logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == 7'h53) || (op == 7'h07) ||
           (op == 7'h27) || (op == 7'h43) ||
           (op == 7'h47) || (op == 7'h4b) ||
           (op == 7'h4f);
  endfunction

  function automatic logic [31:0] gen_data(logic [63:0] a);
    logic [31:0] r;
    r = $urandom();
    if (data_mode == 1)
      return {r[31:7], ops[$urandom_range(12, 0)]};
    if (data_mode == 2)
      return a[2] ? 32'h33 : 32'h53;
    return a[31:0];
  endfunction

  // one clock of memory model + scoreboard
  task automatic step();
    logic exp_rv;
    bit acc, hs, real_rsp;
    req_t r;
    ent_t e;
    @(negedge clk);
    real_rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    if (real_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].data;
    end else begin
      imem_rsp_valid = spurious && (mq.size() == 0) &&
                       ($urandom_range(7, 0) == 0);
      imem_rsp_data  = $urandom();
    end
    #1;
    o_rv   = imem_req_valid;
    o_addr = imem_req_addr;
    o_idv  = id_valid;
    o_pc   = id_pc;
    o_ins  = id_instruction;
    o_fp   = id_is_fp;
    o_rsp  = imem_rsp_valid;
    exp_rv = !redirect_valid && (eq.size() + mq.size() < D);
    checks++;
    if (o_rv !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b",
               cyc, o_rv, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (o_addr !== mpc) begin
        errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h",
                 cyc, o_addr, mpc);
      end
    end
    checks++;
    if (o_idv !== (eq.size() != 0)) begin
      errors++;
      $display("FAIL id_valid cyc=%0d got=%b exp=%b",
               cyc, o_idv, eq.size() != 0);
    end
    e.pc  = 64'h0;
    e.ins = 32'h0;
    if (eq.size() != 0) e = eq[0];
    checks++;
    if (o_pc !== e.pc) begin
      errors++;
      $display("FAIL id_pc cyc=%0d got=%h exp=%h",
               cyc, o_pc, e.pc);
    end
    checks++;
    if (o_ins !== e.ins) begin
      errors++;
      $display("FAIL id_instr cyc=%0d got=%h exp=%h",
               cyc, o_ins, e.ins);
    end
    checks++;
    if (o_fp !== ((eq.size() != 0) && fp_of(e.ins))) begin
      errors++;
      $display("FAIL id_is_fp cyc=%0d got=%b exp=%b",
               cyc, o_fp, (eq.size() != 0) && fp_of(e.ins));
    end
    acc   = exp_rv && imem_req_ready;
    hs    = (eq.size() != 0) && id_ready;
    o_acc = acc;
    @(posedge clk);
    #1;
    if (hs) void'(eq.pop_front());
    if (real_rsp) begin
      r = mq.pop_front();
      if (stale_n > 0) stale_n--;
      else if (!redirect_valid) begin
        e.pc  = r.addr;
        e.ins = r.data;
        eq.push_back(e);
      end
    end
    if (redirect_valid) begin
      eq.delete();
      stale_n = mq.size();
      mpc = redirect_pc & ~64'd3;
    end
    if (acc) begin
      r.addr = mpc;
      r.data = gen_data(mpc);
      r.due  = cyc + $urandom_range(lat_max, lat_min);
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      mq.push_back(r);
      mpc = mpc + 64'd4;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    mq.delete();
    eq.delete();
    mpc = RPC;
    stale_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_due = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valids got=%b%b exp=00",
               imem_req_valid, id_valid);
    end
    checks++;
    if (imem_req_addr !== RPC) begin
      errors++;
      $display("FAIL rst_addr got=%h exp=%h",
               imem_req_addr, RPC);
    end
    checks++;
    if (id_pc !== 64'h0 || id_instruction !== 32'h0 ||
        id_is_fp !== 1'b0) begin
      errors++;
      $display("FAIL rst_id got=%h/%h/%b exp=0",
               id_pc, id_instruction, id_is_fp);
    end
    do_reset();
  endtask

  task automatic test_stream();
    int fa, fv, nv;
    logic [63:0] ep;
    fa = -1; fv = -1; nv = 0; ep = 64'h0;
    do_reset();
    data_mode = 0;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (o_acc && fa < 0) fa = i;
      if (o_idv && fv < 0) fv = i;
      if (o_idv) begin
        nv++;
        checks++;
        if (o_pc !== ep || o_ins !== ep[31:0]) begin
          errors++;
          $display("FAIL stream_seq got=%h/%h exp=%h",
                   o_pc, o_ins, ep);
        end
        ep = ep + 64'd4;
      end
    end
    checks++;
    if (fa != 0 || fv != 2) begin
      errors++;
      $display("FAIL stream_lat got=%0d/%0d exp=0/2", fa, fv);
    end
    checks++;
    if (nv != 14) begin
      errors++;
      $display("FAIL stream_rate got=%0d exp=14", nv);
    end
  endtask

  task automatic test_backpressure();
    int na;
    logic [63:0] ep;
    na = 0; ep = 64'h0;
    do_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1;
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_acc) na++;
    end
    checks++;
    if (na != D || o_rv !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got=%0d/%b exp=%0d/0",
               na, o_rv, D);
    end
    id_ready = 1'b1;
    na = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_acc) na++;
      if (o_idv) begin
        checks++;
        if (o_pc !== ep) begin
          errors++;
          $display("FAIL bp_order got=%h exp=%h", o_pc, ep);
        end
        ep = ep + 64'd4;
      end
    end
    checks++;
    if (na < 8) begin
      errors++;
      $display("FAIL bp_resume got=%0d exp>=8", na);
    end
  endtask

  task automatic test_redirect_flush();
    bit seen;
    seen = 0;
    do_reset();
    data_mode = 0;
    lat_min = 3; lat_max = 3;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    step();
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h1000;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_idv && !seen) begin
        seen = 1;
        checks++;
        if (o_pc !== 64'h1000 || o_ins !== 32'h1000) begin
          errors++;
          $display("FAIL flush_first got=%h/%h exp=1000",
                   o_pc, o_ins);
        end
      end
      if (o_idv) begin
        checks++;
        if (o_pc < 64'h1000) begin
          errors++;
          $display("FAIL flush_stale got=%h exp>=1000", o_pc);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL flush_none got=0 exp=1");
    end
  endtask

  task automatic test_redirect_same_cycle();
    bit seen;
    seen = 0;
    do_reset();
    data_mode = 0;
    lat_min = 2; lat_max = 2;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    repeat (8) step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    step();
    checks++;
    if (!(o_rsp && o_idv)) begin
      errors++;
      $display("FAIL same_setup got=%b%b exp=11", o_rsp, o_idv);
    end
    redirect_valid = 1'b0;
    step();
    checks++;
    if (o_idv !== 1'b0) begin
      errors++;
      $display("FAIL same_empty got=%b exp=0", o_idv);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      if (o_idv && !seen) begin
        seen = 1;
        checks++;
        if (o_pc !== 64'h2000 || o_ins !== 32'h2000) begin
          errors++;
          $display("FAIL same_first got=%h/%h exp=2000",
                   o_pc, o_ins);
        end
      end
    end
  endtask

  task automatic test_fp();
    do_reset();
    data_mode = 2;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_idv) begin
        checks++;
        if (o_fp !== !o_pc[2]) begin
          errors++;
          $display("FAIL fp_flag pc=%h got=%b exp=%b",
                   o_pc, o_fp, !o_pc[2]);
        end
      end
    end
    data_mode = 0;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    data_mode = 0;
    lat_min = 1; lat_max = 1;
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    step();
    checks++;
    if (!o_rv || o_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top got=%b/%h exp=1/fffffffffffffffc",
               o_rv, o_addr);
    end
    step();
    checks++;
    if (o_addr !== 64'h0) begin
      errors++;
      $display("FAIL wrap_zero got=%h exp=0", o_addr);
    end
    repeat (4) step();
    checks++;
    if (!o_idv) begin
      errors++;
      $display("FAIL arst_setup got=%b exp=1", o_idv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req_addr !== RPC ||
        imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst got=%b/%h/%b exp=0/%h/0",
               id_valid, imem_req_addr, imem_req_valid, RPC);
    end
    do_reset();
  endtask

  task automatic test_random();
    int nhs;
    nhs = 0;
    do_reset();
    data_mode = 1;
    lat_min = 1; lat_max = 4;
    spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      id_ready = ($urandom_range(9, 0) < 7);
      redirect_valid = ($urandom_range(24, 0) == 0);
      if ($urandom_range(3, 0) == 0)
        redirect_pc = {32'hFFFF_FFFF, $urandom()};
      else
        redirect_pc = {32'h0, $urandom()};
      step();
      if (o_idv && id_ready) nhs++;
    end
    redirect_valid = 1'b0;
    spurious = 0;
    data_mode = 0;
    checks++;
    if (nhs < 300) begin
      errors++;
      $display("FAIL rand_progress got=%0d exp>=300", nhs);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    id_ready = 1'b0;
    mpc = RPC;
    stale_n = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_fp();
    test_wrap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
